// File: rtl/shift_pkg.sv
// Shared types for the parametrised universal shift register and its frame controller.
package shift_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        SHIFT_UP   = 2'd1,
        SHIFT_DOWN = 2'd2,
        LOAD       = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_RUN  = 2'd1,
        F_PAR  = 2'd2
    } frame_state_t;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 64;

endpackage

// File: rtl/shift_frame_ctrl.sv
// Frame serialiser control: Start acceptance, bit counter, Busy/Done and the effective datapath mode.
// Optional parity phase after the last data bit when SHIFT_FRAME_PARITY_EN is defined.
module shift_frame_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_inh,
    input  shift_mode_t      mode,
    input  logic             start,
`ifdef SHIFT_FRAME_PARITY_EN
    input  logic [WIDTH-1:0] data,
    output logic             parity_phase,
    output logic             parity,
`endif
    output logic             busy,
    output logic             done,
    output shift_mode_t      eff_mode_c
);

    localparam int unsigned CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    frame_state_t  state;
    frame_state_t  state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          done_nxt;
    logic          accept_c;

    assign accept_c = (state == F_IDLE) && start && !clk_inh;

    // State register; done is rewritten on every edge so an inhibit never stretches it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= F_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        if (!clk_inh) begin
            case (state)
                F_IDLE: begin
                    if (start) begin
                        state_nxt = F_RUN;
                        cnt_nxt   = CNT_LAST;
                    end
                end
                F_RUN: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else begin
`ifdef SHIFT_FRAME_PARITY_EN
                        state_nxt = F_PAR;
`else
                        state_nxt = F_IDLE;
                        done_nxt  = 1'b1;
`endif
                    end
                end
                F_PAR: begin
                    state_nxt = F_IDLE;
                    done_nxt  = 1'b1;
                end
                default: state_nxt = F_IDLE;
            endcase
        end
    end

    // Effective mode: Start forces LOAD, a running frame forces SHIFT_UP until the last bit
    always_comb begin
        eff_mode_c = HOLD;
        if (!clk_inh) begin
            case (state)
                F_IDLE:  eff_mode_c = accept_c ? LOAD : mode;
                F_RUN:   eff_mode_c = (cnt != '0) ? SHIFT_UP : HOLD;
                default: eff_mode_c = HOLD;
            endcase
        end
    end

    assign busy = (state != F_IDLE);

`ifdef SHIFT_FRAME_PARITY_EN
    // Parity of the word captured at Start, replayed after the last data bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (accept_c) begin
            parity <= ^data;
        end
    end

    assign parity_phase = (state == F_PAR);
`endif

endmodule

// File: rtl/param_shift_reg.sv
// Parametrised universal shift register (hold / up / down / load) with an MSB-first frame serialiser.
// Optional trailing parity bit per frame when SHIFT_FRAME_PARITY_EN is defined.
module param_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Resetb,
    input  logic             ClkInh,
    input  logic [1:0]       Mode,
    input  logic             DS_LO,
    input  logic             DS_HI,
    input  logic [WIDTH-1:0] P,
    input  logic             Start,
    output logic [WIDTH-1:0] Q,
    output logic             QS,
    output logic             QSb,
    output logic             Busy,
    output logic             Done
);

    shift_mode_t mode;
    shift_mode_t eff_mode_c;
`ifdef SHIFT_FRAME_PARITY_EN
    logic        parity_phase;
    logic        parity;
`endif

    assign mode = shift_mode_t'(Mode);

    shift_frame_ctrl #(
        .WIDTH (WIDTH)
    ) u_frame_ctrl (
        .clk          (Clock),
        .rst_n        (Resetb),
        .clk_inh      (ClkInh),
        .mode         (mode),
        .start        (Start),
`ifdef SHIFT_FRAME_PARITY_EN
        .data         (P),
        .parity_phase (parity_phase),
        .parity       (parity),
`endif
        .busy         (Busy),
        .done         (Done),
        .eff_mode_c   (eff_mode_c)
    );

    always_ff @(posedge Clock or negedge Resetb) begin
        if (!Resetb) begin
            Q <= RESET_VAL;
        end else begin
            case (eff_mode_c)
                SHIFT_UP:   Q <= {Q[WIDTH-2:0], DS_LO};
                SHIFT_DOWN: Q <= {DS_HI, Q[WIDTH-1:1]};
                LOAD:       Q <= P;
                default:    Q <= Q;
            endcase
        end
    end

    // Serial tap follows the shift direction while idle; frames always leave from the top bit
    always_comb begin
        QS = Q[WIDTH-1];
        if (!Busy && (mode == SHIFT_DOWN)) begin
            QS = Q[0];
        end
`ifdef SHIFT_FRAME_PARITY_EN
        if (parity_phase) begin
            QS = parity;
        end
`endif
    end

    assign QSb = ~QS;

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg (WIDTH=8): directed frame scenarios plus randomized traffic
// against a behavioural model. Honours SHIFT_FRAME_PARITY_EN.
module tb_param_shift_reg;

    localparam int unsigned W = 8;
`ifdef SHIFT_FRAME_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_LEN = W + (PAR_EN ? 1 : 0);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inh = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         ds_lo = 1'b0;
    logic         ds_hi = 1'b0;
    logic [W-1:0] p = '0;
    logic         start = 1'b0;
    logic [W-1:0] q;
    logic         qs;
    logic         qsb;
    logic         busy;
    logic         done;

    param_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .Clock  (clk),
        .Resetb (rst_n),
        .ClkInh (inh),
        .Mode   (mode),
        .DS_LO  (ds_lo),
        .DS_HI  (ds_hi),
        .P      (p),
        .Start  (start),
        .Q      (q),
        .QS     (qs),
        .QSb    (qsb),
        .Busy   (busy),
        .Done   (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a frame is "bits still to shift", then an optional parity beat, then done
    logic [W-1:0] m_q;
    bit           m_busy;
    bit           m_done;
    bit           m_par_phase;
    bit           m_par;
    int           m_left;

    function automatic void model_reset();
        m_q = '0; m_busy = 0; m_done = 0; m_par_phase = 0; m_par = 0; m_left = 0;
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (inh) return;
        if (!m_busy && start) begin
            m_q = p; m_busy = 1; m_left = W - 1; m_par = ^p; m_par_phase = 0;
        end else if (m_busy) begin
            if (m_left > 0) begin
                m_q = {m_q[W-2:0], ds_lo};
                m_left--;
            end else if (PAR_EN && !m_par_phase) begin
                m_par_phase = 1;
            end else begin
                m_busy = 0; m_done = 1; m_par_phase = 0;
            end
        end else begin
            case (mode)
                2'd1: m_q = {m_q[W-2:0], ds_lo};
                2'd2: m_q = {ds_hi, m_q[W-1:1]};
                2'd3: m_q = p;
                default: ;
            endcase
        end
    endfunction

    function automatic logic exp_qs();
        if (m_busy && m_par_phase) return m_par;
        if (!m_busy && mode == 2'd2) return m_q[0];
        return m_q[W-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // B4 sent MSB-first
    bit exp_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic test_reset();
        #3 rst_n = 1'b1;
        model_reset();
        mode = 2'd3; p = 8'hFF;
        tick();
        n_checks++;
        if (q !== 8'hFF) begin n_fail++; $display("FAIL reset_preload: q=%0h expected ff", q); end
        mode = 2'd0; start = 1'b1; p = 8'h3C;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_prebusy: busy=%0b expected 1", busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || qs !== 1'b0 || qsb !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: q=%0h busy=%0b done=%0b qs=%0b qsb=%0b expected 00 0 0 0 1",
                     q, busy, done, qs, qsb);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: q=%0h busy=%0b expected 00 0", q, busy);
        end
    endtask

    task automatic test_idle_modes();
        mode = 2'd3; p = 8'hA5;
        tick();
        mode = 2'd1; ds_lo = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (q !== 8'h2F || qs !== 1'b0) begin
            n_fail++; $display("FAIL shift_up: q=%0h qs=%0b expected 2f 0", q, qs);
        end
        mode = 2'd2; ds_hi = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'h17 || qs !== 1'b1 || qsb !== 1'b0) begin
            n_fail++; $display("FAIL shift_down: q=%0h qs=%0b qsb=%0b expected 17 1 0", q, qs, qsb);
        end
        for (int i = 0; i < 40; i++) begin
            mode = 2'($urandom_range(0, 3)); ds_lo = 1'($urandom); ds_hi = 1'($urandom);
            p = 8'($urandom);
            tick();
            n_checks++;
            if (q !== m_q || qs !== exp_qs() || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_random[%0d]: q=%0h qs=%0b busy=%0b expected %0h %0b 0",
                         i, q, qs, busy, m_q, exp_qs());
            end
        end
        mode = 2'd0;
    endtask

    task automatic test_frame();
        mode = 2'd0; ds_lo = 1'b0; p = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0; p = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (qs !== exp_seq[i] || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_bit[%0d]: qs=%0b busy=%0b done=%0b expected %0b 1 0",
                         i, qs, busy, done, exp_seq[i]);
            end
            tick();
        end
`ifdef SHIFT_FRAME_PARITY_EN
        n_checks++;
        if (qs !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL frame_parity: qs=%0b busy=%0b done=%0b expected 0 1 0", qs, busy, done);
        end
        tick();
`endif
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h00) begin
            n_fail++; $display("FAIL frame_end: busy=%0b done=%0b q=%0h expected 0 1 00", busy, done, q);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: done=%0b expected 0", done); end
    endtask

    task automatic test_inhibit();
        bit obs[$];
        bit expq[$];
        int c = 0;
        mode = 2'd0; ds_lo = 1'b0; p = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0;
        while (busy === 1'b1 && c < 30) begin
            obs.push_back(qs);
            inh = (c >= 2 && c <= 4);
            tick();
            c++;
        end
        inh = 1'b0;
        for (int j = 0; j < 8; j++) begin
            expq.push_back(exp_seq[j]);
            if (j == 2) repeat (3) expq.push_back(exp_seq[j]);
        end
        if (PAR_EN) expq.push_back(1'b0);
        n_checks++;
        if (obs.size() != expq.size()) begin
            n_fail++; $display("FAIL inh_busy_len: got %0d cycles expected %0d", obs.size(), expq.size());
        end else begin
            for (int j = 0; j < expq.size(); j++) begin
                n_checks++;
                if (obs[j] !== expq[j]) begin
                    n_fail++; $display("FAIL inh_bit[%0d]: qs=%0b expected %0b", j, obs[j], expq[j]);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL inh_done: done=%0b expected 1", done); end
        inh = 1'b1;
        tick();
        inh = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin
            n_fail++; $display("FAIL inh_done_clear: done=%0b busy=%0b q=%0h expected 0 0 00", done, busy, q);
        end
    endtask

    task automatic test_ignored();
        bit obs[$];
        int c = 0;
        mode = 2'd0; ds_lo = 1'b0; p = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0;
        mode = 2'd3;
        while (busy === 1'b1 && c < 30) begin
            obs.push_back(qs);
            p = 8'($urandom) | 8'h01;
            start = (c == 3);
            tick();
            c++;
        end
        start = 1'b0;
        n_checks++;
        if (obs.size() != FRAME_LEN) begin
            n_fail++; $display("FAIL ign_busy_len: got %0d cycles expected %0d", obs.size(), FRAME_LEN);
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_checks++;
                if (obs[j] !== exp_seq[j]) begin
                    n_fail++; $display("FAIL ign_bit[%0d]: qs=%0b expected %0b", j, obs[j], exp_seq[j]);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1 || q !== 8'h00) begin
            n_fail++; $display("FAIL ign_end: done=%0b q=%0h expected 1 00", done, q);
        end
        mode = 2'd0;
        tick();
    endtask

    task automatic test_reset_midframe();
        mode = 2'd0; p = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h00) begin
            n_fail++; $display("FAIL abort_reset: busy=%0b done=%0b q=%0h expected 0 0 00", busy, done, q);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_done[%0d]: done=%0b busy=%0b expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic e;
        for (int i = 0; i < 400; i++) begin
            inh   = ($urandom_range(0, 4) == 0);
            start = ($urandom_range(0, 5) == 0);
            mode  = 2'($urandom_range(0, 3));
            ds_lo = 1'($urandom);
            ds_hi = 1'($urandom);
            p     = 8'($urandom);
            tick();
            e = exp_qs();
            n_checks++;
            if (q !== m_q || qs !== e || qsb !== ~e || busy !== m_busy || done !== m_done) begin
                n_fail++;
                $display("FAIL random[%0d]: q=%0h qs=%0b qsb=%0b busy=%0b done=%0b expected %0h %0b %0b %0b %0b",
                         i, q, qs, qsb, busy, done, m_q, e, ~e, m_busy, m_done);
            end
        end
        inh = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_modes();
        test_frame();
        test_inhibit();
        test_ignored();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's 8-bit parallel-in/serial-out part.
- Generalised to WIDTH bits with four modes: hold, shift up, shift down, parallel load.
- Adds a frame-serialiser mode (Start/Busy/Done) that emits a loaded word MSB-first on QS.
- Sits between parallel datapaths and serial links; fully synchronous to one clock, with asynchronous active-low reset.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- RESET_VAL, '0, value of Q after reset.

Ports:
- Clock  input  1  single clock; rising edge active.
- Resetb  input  1  asynchronous active-low reset; release is synchronous to Clock.
- ClkInh  input  1  clock inhibit, active-high; when 1, all state freezes.
- Mode  input  2  0=HOLD, 1=SHIFT_UP, 2=SHIFT_DOWN, 3=LOAD.
- DS_LO  input  1  serial input entering Q[0] on SHIFT_UP and during a frame.
- DS_HI  input  1  serial input entering Q[WIDTH-1] on SHIFT_DOWN.
- P  input  WIDTH  parallel load data.
- Start  input  1  one-cycle request: load P and serialise it.
- Q  output  WIDTH  register contents.
- QS  output  1  serial output.
- QSb  output  1  always ~QS.
- Busy  output  1  frame in progress.
- Done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (Resetb=0, asynchronous): Q=RESET_VAL, Busy=0, Done=0, counter=0, QS=RESET_VAL[WIDTH-1], QSb=~QS.
- Priority at each rising edge: Resetb > ClkInh > (Start when idle) > frame in progress > Mode.
- ClkInh=1: Q, counter, Busy and the parity phase hold. Done still clears on that edge, so a Done pulse is never stretched.
- Idle (Busy=0), Start=0:
  - HOLD: Q unchanged.
  - SHIFT_UP: Q <= {Q[WIDTH-2:0], DS_LO}.
  - SHIFT_DOWN: Q <= {DS_HI, Q[WIDTH-1:1]}.
  - LOAD: Q <= P.
  - QS = Q[WIDTH-1] in every mode except SHIFT_DOWN, where QS = Q[0]. QS is combinational on Mode while idle.
- Frame start: Start=1 while idle at edge k.
  - Q <= P, Busy <= 1, counter <= WIDTH-1. Mode is ignored.
  - After edge k, QS = P[WIDTH-1].
- Frame running: Busy=1, at each uninhibited edge:
  - If counter > 0: shift up with DS_LO, counter decrements.
  - If counter = 0: Busy <= 0, Done <= 1, Q holds (no shift).
  - QS = Q[WIDTH-1] throughout.
  - Net timing: bit P[i] is on QS during cycle k+(WIDTH-1-i); Done is high for the cycle after edge k+WIDTH.
- Start while Busy: ignored, never queued.
- Start and ClkInh together: ignored for that edge; the requester must hold or re-assert Start.
- Mode changes while Busy: ignored.
- Reset mid-frame: frame aborts immediately; no Done.
- Done is a registered pulse, cleared on the edge following its assertion.
- Counter width is $clog2(WIDTH).

Optional Feature:
- Macro: SHIFT_FRAME_PARITY_EN.
- Defined:
  - When counter reaches 0, the next edge enters a parity phase instead of finishing.
  - In the parity phase QS = even parity (XOR) of the P captured at Start; parity is registered at Start.
  - The following uninhibited edge clears Busy and pulses Done.
  - Busy therefore lasts WIDTH+1 cycles; Done follows edge k+WIDTH+1.
  - Idle modes are unaffected.
- Undefined: no parity register, no parity phase; timing exactly as above.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {HOLD, SHIFT_UP, SHIFT_DOWN, LOAD};
  - localparam MIN_WIDTH = 2.
- One sub-module, shift_frame_ctrl: counter, Busy/Done, parity phase, Start acceptance. It drives the effective mode into the datapath.
- Datapath (register plus QS mux) stays in param_shift_reg.

Test Plan:
- WIDTH=8: reset with Resetb=0 mid-clock -> Q=0x00, Busy=0, Done=0 immediately, with no clock edge needed.
- Idle LOAD P=0xA5, then 3x SHIFT_UP with DS_LO=1 -> Q=0x2F, QS=0. Then 1x SHIFT_DOWN with DS_HI=0 -> Q=0x17, QS=1.
- Start with P=0xB4 -> QS sequence 1,0,1,1,0,1,0,0 over 8 cycles; Busy high 8 cycles; Done a single-cycle pulse after the 8th bit; Q=0x00 with DS_LO=0.
- Frame with ClkInh=1 for 3 cycles after bit 2 -> bit 2 held on QS for 4 cycles; total Busy 11 cycles; bit order intact.
- Start re-asserted at cycle 3 of a frame, and Mode=LOAD during the frame -> both ignored; output identical to the uninterrupted frame.
- Resetb low at bit 5 -> Busy=0, no Done. With SHIFT_FRAME_PARITY_EN, P=0xB4 -> 9th QS bit=0, Busy 9 cycles.
